cva6_axi_txn_limiter: RTL and testbench
=======================================

Name: cva6_axi_txn_limiter

Overview:
- Sits directly downstream of the cache subsystem's merged AXI master port, between it and the SoC interconnect.
- Forwards all five AXI channels unchanged.
- Counts outstanding read and write transactions and throttles new AR/AW issue at configurable limits.
- Provides a drain handshake for fence/flush sequencing, plus a sticky bus-error flag from R/B response codes.

Parameters:
- MaxReads, 4, maximum outstanding read transactions (AR accepted, R last not yet accepted); range 1..15.
- MaxWrites, 4, maximum outstanding write transactions (AW accepted, B not yet accepted); range 1..15.
- axi_req_t, ariane_axi::req_t, AXI request struct type.
- axi_rsp_t, ariane_axi::resp_t, AXI response struct type.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- slv_req_i  in  axi_req_t  request from the cache subsystem.
- slv_resp_o  out  axi_rsp_t  response to the cache subsystem.
- mst_req_o  out  axi_req_t  request to the interconnect.
- mst_resp_i  in  axi_rsp_t  response from the interconnect.
- drain_i  in  1  level; block new AR/AW while high.
- drained_o  out  1  drain_i high and nothing outstanding.
- bus_error_o  out  1  sticky; set on any SLVERR/DECERR on R or B.
- clr_error_i  in  1  clears bus_error_o.
- rd_outstanding_o  out  4  current outstanding read count.
- wr_outstanding_o  out  4  current outstanding write count.

Behaviour:
- Reset values:
  - rd_cnt = 0, wr_cnt = 0, ar_lock = 0, aw_lock = 0, bus_error_o = 0.
  - drained_o = 0 (drain_i is sampled combinationally; drained_o = 0 while in reset).
  - mst_req_o valids follow gating with both counters at 0.
- Pass-through:
  - W, R and B payloads and valid/ready are combinational pass-through; zero latency.
  - AR/AW payloads pass through; only their valid/ready are gated.
- AR gating:
  - ar_block = drain_i OR (rd_cnt == MaxReads).
  - Blocking uses registered counts only; a retire in the same cycle does not unblock (no comb path from R to AR).
  - mst.ar_valid = slv.ar_valid AND (ar_lock OR NOT ar_block).
  - slv.ar_ready = mst.ar_ready AND (ar_lock OR NOT ar_block).
- AR lock (AXI valid stability):
  - ar_lock sets when mst.ar_valid is high and mst.ar_ready is low.
  - ar_lock clears on AR handshake.
  - While ar_lock is set, the AR is forwarded even if ar_block has risen (e.g. drain_i asserted mid-request).
- AW gating: identical to AR, using wr_cnt, MaxWrites and aw_lock.
- rd_cnt update:
  - +1 on mst AR handshake.
  - -1 on mst R handshake with r.last.
  - Both in the same cycle: unchanged.
- wr_cnt update:
  - +1 on AW handshake.
  - -1 on B handshake.
  - Both in the same cycle: unchanged.
- Counters never exceed the Max limits and never underflow. A retire event while the count is 0 is a protocol violation: flag it with an assertion and saturate at 0.
- drained_o = drain_i AND rd_cnt == 0 AND wr_cnt == 0 AND NOT ar_lock AND NOT aw_lock. It is combinational from registered state plus drain_i.
- Drain timing: deasserting drain_i re-enables issue in the same cycle.
- Errors:
  - bus_error_o sets on an R handshake with r.resp[1] = 1, or a B handshake with b.resp[1] = 1.
  - clr_error_i clears it next cycle.
  - Set and clear in the same cycle: set wins.
- Write ordering:
  - W beats are not limited; the upstream W mux already orders them by AW.
  - wr_cnt covers the AW->B lifetime, so drained_o implies all W data has been sent.
- Reset mid-transaction: all state clears immediately; the interconnect must be reset together with this block.

Decomposition:
- No new package types. The counter width localparam is $clog2(Max+1), capped at 4 bits to match the outputs.
- One natural sub-module, cva6_axi_txn_counter, instantiated twice (read and write). It contains:
  - up/down counter
  - limit compare
  - valid lock
  - gating logic
  - underflow assertion

Test Plan:
- MaxReads = 2; issue 3 back-to-back ARs with the slave holding R -> third AR stalls (slv ar_ready = 0), rd_outstanding_o = 2; one R last accepted -> third AR issues the following cycle, count stays at 2.
- rd_cnt = 2 with R last and a new AR handshake attempted in the same cycle -> new AR blocked that cycle (registered limit), count 1; next cycle the AR issues, count 2.
- AW presented with mst aw_ready low, then drain_i rises -> aw_valid stays high until handshake; wr_cnt = 1; drained_o = 0 until B accepted, then drained_o = 1.
- drain_i high with counters at 0 and no locks -> drained_o = 1 the same cycle; ar_valid to the interconnect stays 0 while the cache requests.
- B with resp = 2'b10 -> bus_error_o = 1 next cycle; clr_error_i together with an R resp = 2'b11 in the same cycle -> stays 1; clr_error_i alone -> 0.
- Async reset asserted with rd_cnt = 3 and wr_cnt = 1 -> all counts, locks and bus_error_o are 0 immediately; after release, 4 ARs are accepted with MaxReads = 4.

Source files
------------

// File: rtl/cva6_axi_txn_limiter_pkg.sv
// Shared AXI request/response types and sizing helper for the transaction limiter.
// The struct shapes follow the ariane_axi req_t/resp_t field naming.
package cva6_axi_txn_limiter_pkg;

  localparam int unsigned IdW   = 4;
  localparam int unsigned AddrW = 64;
  localparam int unsigned DataW = 64;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
  } ax_chan_t;

  typedef struct packed {
    logic [DataW-1:0]   data;
    logic [DataW/8-1:0] strb;
    logic               last;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

  // Counter width for a limit, capped to the 4-bit outstanding-count outputs.
  function automatic int unsigned cnt_width(input int unsigned max);
    int unsigned w;
    w = $clog2(max + 1);
    return (w > 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/cva6_axi_txn_counter.sv
// Outstanding-transaction counter for one address channel: limit compare,
// valid-stability lock and valid/ready gating.
module cva6_axi_txn_counter
  import cva6_axi_txn_limiter_pkg::*;
#(
  parameter int unsigned Max = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       drain_i,
  input  logic       slv_valid_i,
  input  logic       mst_ready_i,
  input  logic       retire_i,
  output logic       mst_valid_o,
  output logic       slv_ready_o,
  output logic       lock_o,
  output logic [3:0] cnt_o
);

  localparam int unsigned CntW = cnt_width(Max);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lock_q, lock_d;
  logic            block, open, issue;

  // Registered count only: a same-cycle retire never reopens the gate.
  assign block       = drain_i | (cnt_q == CntW'(Max));
  assign open        = lock_q | ~block;
  assign mst_valid_o = slv_valid_i & open;
  assign slv_ready_o = mst_ready_i & open;
  assign issue       = mst_valid_o & mst_ready_i;
  assign lock_o      = lock_q;
  assign cnt_o       = 4'(cnt_q);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({issue, retire_i})
      2'b10:   if (cnt_q != CntW'(Max)) cnt_d = cnt_q + CntW'(1);
      2'b01:   if (cnt_q != '0)         cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Once valid is shown downstream it must stay up until the handshake.
  always_comb begin
    lock_d = lock_q;
    if (issue)                           lock_d = 1'b0;
    else if (mst_valid_o && !mst_ready_i) lock_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end

`ifndef SYNTHESIS
  no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    retire_i |-> (cnt_q != '0));
`endif

endmodule

// File: rtl/cva6_axi_txn_limiter.sv
// AXI pass-through that caps outstanding reads/writes, offers a drain
// handshake for fences, and latches error responses.
module cva6_axi_txn_limiter
  import cva6_axi_txn_limiter_pkg::*;
#(
  parameter int unsigned MaxReads  = 4,
  parameter int unsigned MaxWrites = 4,
  parameter type         axi_req_t = req_t,
  parameter type         axi_rsp_t = resp_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  axi_req_t   slv_req_i,
  output axi_rsp_t   slv_resp_o,
  output axi_req_t   mst_req_o,
  input  axi_rsp_t   mst_resp_i,
  input  logic       drain_i,
  output logic       drained_o,
  output logic       bus_error_o,
  input  logic       clr_error_i,
  output logic [3:0] rd_outstanding_o,
  output logic [3:0] wr_outstanding_o
);

  logic r_hs, b_hs;
  logic ar_valid, ar_ready, ar_lock;
  logic aw_valid, aw_ready, aw_lock;
  logic err_set, err_q;

  assign r_hs = mst_resp_i.r_valid & slv_req_i.r_ready;
  assign b_hs = mst_resp_i.b_valid & slv_req_i.b_ready;

  cva6_axi_txn_counter #(.Max(MaxReads)) i_rd_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .drain_i     (drain_i),
    .slv_valid_i (slv_req_i.ar_valid),
    .mst_ready_i (mst_resp_i.ar_ready),
    .retire_i    (r_hs & mst_resp_i.r.last),
    .mst_valid_o (ar_valid),
    .slv_ready_o (ar_ready),
    .lock_o      (ar_lock),
    .cnt_o       (rd_outstanding_o)
  );

  // Write lifetime runs AW->B, so W beats are covered without separate tracking.
  cva6_axi_txn_counter #(.Max(MaxWrites)) i_wr_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .drain_i     (drain_i),
    .slv_valid_i (slv_req_i.aw_valid),
    .mst_ready_i (mst_resp_i.aw_ready),
    .retire_i    (b_hs),
    .mst_valid_o (aw_valid),
    .slv_ready_o (aw_ready),
    .lock_o      (aw_lock),
    .cnt_o       (wr_outstanding_o)
  );

  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.ar_valid  = ar_valid;
    mst_req_o.aw_valid  = aw_valid;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.aw_ready = aw_ready;
  end

  assign drained_o = rst_ni & drain_i & (rd_outstanding_o == 4'd0) &
                     (wr_outstanding_o == 4'd0) & ~ar_lock & ~aw_lock;

  // SLVERR/DECERR both have resp[1] set; a new error beats a clear.
  assign err_set = (r_hs & mst_resp_i.r.resp[1]) | (b_hs & mst_resp_i.b.resp[1]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          err_q <= 1'b0;
    else if (err_set)     err_q <= 1'b1;
    else if (clr_error_i) err_q <= 1'b0;
  end

  assign bus_error_o = err_q;

endmodule

// File: tb/tb_cva6_axi_txn_limiter.sv
// Directed bench: limit/registered-gating, lock across drain, drain handshake,
// sticky error and async reset on two limiter instances.
module tb_cva6_axi_txn_limiter;
  import cva6_axi_txn_limiter_pkg::*;

  logic       clk, rst_n, drain, clr;
  req_t       req_a, req_b, mst_req_a, mst_req_b;
  resp_t      resp, slv_resp_a, slv_resp_b;
  logic       drained_a, drained_b, err_a, err_b;
  logic [3:0] rd_a, wr_a, rd_b, wr_b;
  int         n_chk = 0, n_pass = 0;

  cva6_axi_txn_limiter #(.MaxReads(2), .MaxWrites(2)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(req_a), .slv_resp_o(slv_resp_a),
    .mst_req_o(mst_req_a), .mst_resp_i(resp), .drain_i(drain),
    .drained_o(drained_a), .bus_error_o(err_a), .clr_error_i(clr),
    .rd_outstanding_o(rd_a), .wr_outstanding_o(wr_a)
  );

  cva6_axi_txn_limiter #(.MaxReads(4), .MaxWrites(4)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(req_b), .slv_resp_o(slv_resp_b),
    .mst_req_o(mst_req_b), .mst_resp_i(resp), .drain_i(drain),
    .drained_o(drained_b), .bus_error_o(err_b), .clr_error_i(clr),
    .rd_outstanding_o(rd_b), .wr_outstanding_o(wr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_a = '0; req_b = '0; resp = '0; drain = 1'b1; clr = 1'b0;
    #3;
    chk("rst_drained", drained_a, 0);
    chk("rst_rd", rd_a, 0);
    chk("rst_wr", wr_a, 0);
    chk("rst_err", err_a, 0);
    drain = 1'b0;
    #4 rst_n = 1'b1;
    tick();

    // limit of 2 reads on A, R held off
    resp.ar_ready = 1'b1; req_a.ar_valid = 1'b1; req_a.ar.addr = 64'h1000;
    #1;
    chk("ar1_mvalid", mst_req_a.ar_valid, 1);
    chk("ar1_sready", slv_resp_a.ar_ready, 1);
    chk("ar_addr_pass", mst_req_a.ar.addr, 64'h1000);
    tick();
    tick();
    chk("ar3_rd", rd_a, 2);
    chk("ar3_mvalid", mst_req_a.ar_valid, 0);
    chk("ar3_sready", slv_resp_a.ar_ready, 0);
    tick();
    // R last at the limit: AR stays blocked this cycle
    resp.r_valid = 1'b1; resp.r.last = 1'b1; resp.r.data = 64'hdead; req_a.r_ready = 1'b1;
    #1;
    chk("rlast_sready", slv_resp_a.ar_ready, 0);
    chk("r_data_pass", slv_resp_a.r.data, 64'hdead);
    tick();
    resp.r_valid = 1'b0;
    #1;
    chk("after_r_rd", rd_a, 1);
    chk("after_r_sready", slv_resp_a.ar_ready, 1);
    tick();
    req_a.ar_valid = 1'b0;
    chk("reissue_rd", rd_a, 2);
    resp.r_valid = 1'b1;
    tick();
    tick();
    resp.r_valid = 1'b0; req_a.r_ready = 1'b0; resp.r.last = 1'b0;
    #1;
    chk("rd_emptied", rd_a, 0);

    // AW stalled, then drain rises: lock keeps valid up
    resp.aw_ready = 1'b0; req_a.aw_valid = 1'b1;
    #1;
    chk("aw_mvalid", mst_req_a.aw_valid, 1);
    chk("aw_sready", slv_resp_a.aw_ready, 0);
    tick();
    drain = 1'b1; req_b.ar_valid = 1'b1;
    #1;
    chk("aw_lock_mvalid", mst_req_a.aw_valid, 1);
    chk("aw_lock_drained", drained_a, 0);
    chk("b_drained_idle", drained_b, 1);
    chk("b_drain_ar_mvalid", mst_req_b.ar_valid, 0);
    chk("b_drain_ar_sready", slv_resp_b.ar_ready, 0);
    resp.aw_ready = 1'b1;
    #1;
    chk("aw_hs_sready", slv_resp_a.aw_ready, 1);
    tick();
    req_a.aw_valid = 1'b0; resp.aw_ready = 1'b0;
    #1;
    chk("aw_wr", wr_a, 1);
    chk("aw_pend_drained", drained_a, 0);
    resp.b_valid = 1'b1; resp.b.resp = 2'b10; req_a.b_ready = 1'b1;
    tick();
    resp.b_valid = 1'b0; req_a.b_ready = 1'b0;
    #1;
    chk("b_wr", wr_a, 0);
    chk("b_drained", drained_a, 1);
    chk("b_err_set", err_a, 1);
    chk("b_err_other", err_b, 0);

    // clear together with an error response: set wins
    resp.r_valid = 1'b1; resp.r.resp = 2'b11; resp.r.last = 1'b0; req_a.r_ready = 1'b1; clr = 1'b1;
    tick();
    resp.r_valid = 1'b0; req_a.r_ready = 1'b0;
    #1;
    chk("err_set_wins", err_a, 1);
    tick();
    clr = 1'b0;
    #1;
    chk("err_cleared", err_a, 0);

    // drain release re-enables issue in the same cycle
    drain = 1'b0;
    #1;
    chk("undrain_mvalid", mst_req_b.ar_valid, 1);
    chk("undrain_drained", drained_b, 0);
    tick();
    tick();
    tick();
    resp.ar_ready = 1'b0; req_b.aw_valid = 1'b1; resp.aw_ready = 1'b1;
    tick();
    req_b.aw_valid = 1'b0; resp.aw_ready = 1'b0;
    resp.r_valid = 1'b1; resp.r.resp = 2'b10; req_b.r_ready = 1'b1;
    tick();
    resp.r_valid = 1'b0; req_b.r_ready = 1'b0;
    #1;
    chk("pre_rst_rd", rd_b, 3);
    chk("pre_rst_wr", wr_b, 1);
    chk("pre_rst_err", err_b, 1);

    // async reset mid-transaction
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rd", rd_b, 0);
    chk("arst_wr", wr_b, 0);
    chk("arst_err", err_b, 0);
    drain = 1'b1;
    #1;
    chk("arst_lock_clear", mst_req_b.ar_valid, 0);
    drain = 1'b0;
    #1 rst_n = 1'b1;
    resp.ar_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("post_rst_ar%0d", i), slv_resp_b.ar_ready, 1);
      tick();
    end
    chk("post_rst_full_sready", slv_resp_b.ar_ready, 0);
    chk("post_rst_rd", rd_b, 4);
    req_b.ar_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
